alu_op_dispatcher: RTL and testbench

//  Registered, handshaked successor to the ALU function decoder.
//  - Accepts one ALU operation request at a time.
//  - Decodes the top SEL_W bits of ALU_FUN into a one-hot enable for one of N_UNITS execution units.
//  - Holds that enable until the selected unit reports done, then pulses OUT_VALID.
//  - Sits between the register-file/control FSM and the ALU unit datapaths; supports multi-cycle units.

---
 rtl/alu_op_dispatcher.sv | 122 ++++++++++++
 tb/tb_alu_op_dispatcher.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_dispatcher.sv
// Registered, handshaked ALU op dispatcher: decodes ALU_FUN MSBs into a held one-hot unit enable.
// Optional macro ALU_TIMEOUT_EN adds an abort after TIMEOUT execute cycles without unit_done.
module alu_op_dispatcher #(
  parameter int FUN_W   = 4,
  parameter int SEL_W   = 2,
  parameter int N_UNITS = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     enable,
  input  logic [FUN_W-1:0]         ALU_FUN,
  output logic                     req_ready,
  output logic [N_UNITS-1:0]       unit_enable,
  output logic [FUN_W-SEL_W-1:0]   unit_fun,
  input  logic [N_UNITS-1:0]       unit_done,
  output logic                     OUT_VALID,
  output logic                     busy,
  output logic                     illegal,
  output logic                     timeout
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  if (N_UNITS < 1 || N_UNITS > 2**SEL_W || SEL_W >= FUN_W || TIMEOUT < 1) begin : g_param_err
    $error("alu_op_dispatcher: inconsistent parameters");
  end

  state_t                   state_q;
  logic [N_UNITS-1:0]       unit_enable_q;
  logic [FUN_W-SEL_W-1:0]   fun_q;
  logic                     out_valid_q;
  logic                     illegal_q;

  logic [SEL_W-1:0]         req_sel;
  logic                     sel_legal;
  logic                     done_hit;

  assign req_sel   = ALU_FUN[FUN_W-1 -: SEL_W];
  assign sel_legal = (int'(req_sel) < N_UNITS);
  // unit_enable_q is one-hot on the latched select, so masking picks only the selected unit's done.
  assign done_hit  = |(unit_done & unit_enable_q);

`ifdef ALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             at_limit;

  // cnt_q holds (EXEC cycle index - 1), so the TIMEOUT-th cycle sees TIMEOUT-1.
  assign at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      unit_enable_q <= '0;
      fun_q         <= '0;
      out_valid_q   <= 1'b0;
      illegal_q     <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (enable) begin
            if (sel_legal) begin
              state_q       <= EXEC;
              unit_enable_q <= N_UNITS'(1) << req_sel;
              fun_q         <= ALU_FUN[FUN_W-SEL_W-1:0];
`ifdef ALU_TIMEOUT_EN
              cnt_q         <= '0;
`endif
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          // Done takes priority over the timeout limit in the same cycle.
          if (done_hit) begin
            state_q       <= IDLE;
            unit_enable_q <= '0;
            out_valid_q   <= 1'b1;
          end
`ifdef ALU_TIMEOUT_EN
          else if (at_limit) begin
            state_q       <= IDLE;
            unit_enable_q <= '0;
            timeout_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q       <= IDLE;
          unit_enable_q <= '0;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q == EXEC);
  assign unit_enable = unit_enable_q;
  assign unit_fun    = fun_q;
  assign OUT_VALID   = out_valid_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Directed testbench for alu_op_dispatcher (4-unit main instance plus a 3-unit instance for illegal selects).
module tb_alu_op_dispatcher;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic [3:0] ALU_FUN;
  logic [3:0] unit_done;
  logic       req_ready;
  logic [3:0] unit_enable;
  logic [1:0] unit_fun;
  logic       OUT_VALID, busy, illegal, timeout;

  logic       enable3;
  logic [3:0] fun3;
  logic [2:0] done3;
  logic       req_ready3;
  logic [2:0] unit_enable3;
  logic [1:0] unit_fun3;
  logic       out_valid3, busy3, illegal3, timeout3;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  alu_op_dispatcher #(.FUN_W(4), .SEL_W(2), .N_UNITS(4), .TIMEOUT(15)) u_dut (
    .CLK(CLK), .RST(RST), .enable(enable), .ALU_FUN(ALU_FUN),
    .req_ready(req_ready), .unit_enable(unit_enable), .unit_fun(unit_fun),
    .unit_done(unit_done), .OUT_VALID(OUT_VALID), .busy(busy),
    .illegal(illegal), .timeout(timeout)
  );

  alu_op_dispatcher #(.FUN_W(4), .SEL_W(2), .N_UNITS(3), .TIMEOUT(15)) u_dut3 (
    .CLK(CLK), .RST(RST), .enable(enable3), .ALU_FUN(fun3),
    .req_ready(req_ready3), .unit_enable(unit_enable3), .unit_fun(unit_fun3),
    .unit_done(done3), .OUT_VALID(out_valid3), .busy(busy3),
    .illegal(illegal3), .timeout(timeout3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RST = 1'b0; enable = 1'b0; ALU_FUN = 4'h0; unit_done = 4'h0;
    enable3 = 1'b0; fun3 = 4'h0; done3 = 3'h0;
    tick_n(2);
    // Reset values
    check("rst_req_ready", req_ready, 1);
    check("rst_unit_enable", unit_enable, 0);
    check("rst_unit_fun", unit_fun, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_busy", busy, 0);
    check("rst_illegal", illegal, 0);
    check("rst_timeout", timeout, 0);
    #3 RST = 1'b1;
    tick();

    // Single op: FUN=0110 -> unit 1, sub-op 10, done at T+3
    enable = 1'b1; ALU_FUN = 4'b0110;
    check("t2_ready_T", req_ready, 1);
    tick();
    enable = 1'b0;
    check("t2_ue_T1", unit_enable, 4'b0010);
    check("t2_fun_T1", unit_fun, 2'b10);
    check("t2_busy_T1", busy, 1);
    check("t2_ready_T1", req_ready, 0);
    check("t2_ov_T1", OUT_VALID, 0);
    tick();
    check("t2_ue_T2", unit_enable, 4'b0010);
    tick();
    check("t2_ue_T3", unit_enable, 4'b0010);
    check("t2_ov_T3", OUT_VALID, 0);
    unit_done = 4'b0010;
    tick();
    unit_done = 4'b0000;
    check("t2_ov_T4", OUT_VALID, 1);
    check("t2_ue_T4", unit_enable, 0);
    check("t2_ready_T4", req_ready, 1);
    check("t2_busy_T4", busy, 0);
    tick();
    check("t2_ov_T5", OUT_VALID, 0);
    check("t2_timeout", timeout, 0);

    // Back-to-back: FUN=0 done at T+1, then FUN=C in the OUT_VALID cycle
    enable = 1'b1; ALU_FUN = 4'h0;
    tick();
    enable = 1'b0;
    check("t3_ue0", unit_enable, 4'b0001);
    unit_done = 4'b0001;
    tick();
    unit_done = 4'b0000;
    check("t3_ov_first", OUT_VALID, 1);
    check("t3_ue_gap", unit_enable, 0);
    check("t3_ready_ov", req_ready, 1);
    enable = 1'b1; ALU_FUN = 4'hC;
    tick();
    enable = 1'b0;
    check("t3_ue3", unit_enable, 4'b1000);
    check("t3_fun3", unit_fun, 2'b00);
    check("t3_ov_clear", OUT_VALID, 0);
    check("t3_illegal", illegal, 0);
    unit_done = 4'b1000;
    tick();
    unit_done = 4'b0000;
    check("t3_ov_second", OUT_VALID, 1);
    tick();

    // Ignore rules: foreign done and request during EXEC
    enable = 1'b1; ALU_FUN = 4'h3;
    tick();
    check("t4_ue0", unit_enable, 4'b0001);
    check("t4_fun", unit_fun, 2'b11);
    unit_done = 4'b0100; ALU_FUN = 4'h4;
    check("t4_ready_exec", req_ready, 0);
    tick();
    check("t4_ue_hold", unit_enable, 4'b0001);
    check("t4_fun_hold", unit_fun, 2'b11);
    check("t4_no_ov", OUT_VALID, 0);
    enable = 1'b0; unit_done = 4'b0001;
    tick();
    unit_done = 4'b0000;
    check("t4_ov", OUT_VALID, 1);
    tick();
    check("t4_ue_idle", unit_enable, 0);
    check("t4_ov_clear", OUT_VALID, 0);

    // Illegal select on the 3-unit instance
    enable3 = 1'b1; fun3 = 4'hF;
    tick();
    enable3 = 1'b0;
    check("t5_illegal", illegal3, 1);
    check("t5_ue", unit_enable3, 0);
    check("t5_ready", req_ready3, 1);
    check("t5_busy", busy3, 0);
    tick();
    check("t5_illegal_clear", illegal3, 0);
    enable3 = 1'b1; fun3 = 4'h9;
    tick();
    enable3 = 1'b0;
    check("t5_legal_ue", unit_enable3, 3'b100);
    check("t5_legal_ill", illegal3, 0);
    done3 = 3'b100;
    tick();
    done3 = 3'b000;
    check("t5_legal_ov", out_valid3, 1);

`ifdef ALU_TIMEOUT_EN
    // Timeout after the 15th EXEC cycle without done
    enable = 1'b1; ALU_FUN = 4'h4;
    tick();
    enable = 1'b0;
    tick_n(14);
    check("t6_ue_limit", unit_enable, 4'b0010);
    check("t6_to_early", timeout, 0);
    tick();
    check("t6_timeout", timeout, 1);
    check("t6_ue_drop", unit_enable, 0);
    check("t6_no_ov", OUT_VALID, 0);
    check("t6_ready", req_ready, 1);
    tick();
    check("t6_timeout_clear", timeout, 0);
    // Done exactly at the limit wins
    enable = 1'b1; ALU_FUN = 4'h4;
    tick();
    enable = 1'b0;
    tick_n(14);
    unit_done = 4'b0010;
    tick();
    unit_done = 4'b0000;
    check("t6_done_ov", OUT_VALID, 1);
    check("t6_done_no_to", timeout, 0);
    tick();
`endif

    // Asynchronous reset mid-EXEC
    enable = 1'b1; ALU_FUN = 4'h8;
    tick();
    enable = 1'b0;
    check("t1_ue_pre", unit_enable, 4'b0100);
    #2 RST = 1'b0;
    #1;
    check("t1_async_ue", unit_enable, 0);
    check("t1_async_ready", req_ready, 1);
    check("t1_async_busy", busy, 0);
    check("t1_async_fun", unit_fun, 0);
    unit_done = 4'b0100;
    tick();
    unit_done = 4'b0000;
    check("t1_no_ov", OUT_VALID, 0);
    check("t1_ue_held0", unit_enable, 0);
    #3 RST = 1'b1;
    tick();
    check("t1_after_ready", req_ready, 1);
    check("t1_after_ov", OUT_VALID, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
